// File: rtl/servo_sequencer_pkg.sv
// ============================================================================
// Module      : servo_sequencer_pkg
// Description : Shared state encoding and default idle position for servo
//               playback and the top-level mode FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package servo_sequencer_pkg;

    localparam int c_CENTER_DEFAULT = 128;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SLEW  = 3'd2,
        ST_DWELL = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/servo_sequencer_axis_slew.sv
// ============================================================================
// Module      : axis_slew
// Description : One servo axis: latches a target and steps the position
//               toward it by at most STEP per tick, clamping on arrival.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axis_slew
    import servo_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STEP       = 1,
    parameter int CENTER     = c_CENTER_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] target,
    output logic [DATA_WIDTH-1:0] pos,
    output logic                  at_target
);

    localparam int c_POS_MAX  = (1 << DATA_WIDTH) - 1;
    localparam int c_STEP_SAT = (STEP > c_POS_MAX) ? c_POS_MAX : STEP;
    localparam logic [DATA_WIDTH-1:0] c_STEP       = DATA_WIDTH'(c_STEP_SAT);
    localparam logic [DATA_WIDTH-1:0] c_CENTER_POS = DATA_WIDTH'(CENTER);

    logic [DATA_WIDTH-1:0] r_target;
    logic [DATA_WIDTH-1:0] r_pos;
    logic [DATA_WIDTH-1:0] w_diff;
    logic [DATA_WIDTH-1:0] w_stepped;
    logic [DATA_WIDTH-1:0] w_pos_next;
    logic                  w_up;

    always_comb begin
        w_up   = r_target > r_pos;
        w_diff = w_up ? (r_target - r_pos) : (r_pos - r_target);
        if (w_diff <= c_STEP) begin
            w_stepped = r_target;
        end else if (w_up) begin
            w_stepped = r_pos + c_STEP;
        end else begin
            w_stepped = r_pos - c_STEP;
        end
        w_pos_next = tick ? w_stepped : r_pos;
    end

    // Reflects the position after this edge, so the sequencer can leave SLEW
    // on the same edge that completes the final step.
    assign at_target = (w_pos_next == r_target);
    assign pos       = r_pos;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_target <= c_CENTER_POS;
            r_pos    <= c_CENTER_POS;
        end else begin
            if (load) begin
                r_target <= target;
            end
            r_pos <= w_pos_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/servo_sequencer.sv
// ============================================================================
// Module      : servo_sequencer
// Description : Plays back ROM waypoints on three servo axes with rate-limited
//               slewing and a per-waypoint dwell, optionally looping.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module servo_sequencer
    import servo_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int NUM_STEPS   = 8,
    parameter int TICK_DIV    = 500000,
    parameter int DWELL_TICKS = 50,
    parameter int STEP        = 1,
    parameter int CENTER      = c_CENTER_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data_x,
    input  logic [DATA_WIDTH-1:0] rom_data_y,
    input  logic [DATA_WIDTH-1:0] rom_data_z,
    output logic [DATA_WIDTH-1:0] pos_x,
    output logic [DATA_WIDTH-1:0] pos_y,
    output logic [DATA_WIDTH-1:0] pos_z,
    output logic                  busy,
    output logic                  done
);

    localparam int c_PRE_W   = $clog2(TICK_DIV);
    localparam int c_DWELL_W = $clog2(DWELL_TICKS + 1);
    localparam logic [c_PRE_W-1:0]    c_PRE_LAST   = c_PRE_W'(TICK_DIV - 1);
    localparam logic [c_DWELL_W-1:0]  c_DWELL_LAST = c_DWELL_W'(DWELL_TICKS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_IDX_LAST   = ADDR_WIDTH'(NUM_STEPS - 1);

    seq_state_t             r_state;
    logic [ADDR_WIDTH-1:0]  r_idx;
    logic [c_PRE_W-1:0]     r_pre;
    logic [c_DWELL_W-1:0]   r_dwell;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_tick;
    logic [c_PRE_W-1:0]     w_pre_next;
    logic                   w_axis_tick;
    logic                   w_axis_load;
    logic [DATA_WIDTH-1:0]  w_rom [3];
    logic [DATA_WIDTH-1:0]  w_pos [3];
    logic [2:0]             w_at_target;

    assign w_tick      = (r_pre == c_PRE_LAST);
    assign w_pre_next  = w_tick ? '0 : r_pre + 1'b1;
    // stop must freeze the axes even when it lands on a tick edge.
    assign w_axis_tick = w_tick && (r_state == ST_SLEW) && !stop;
    assign w_axis_load = (r_state == ST_LOAD) && !stop;

    assign w_rom[0] = rom_data_x;
    assign w_rom[1] = rom_data_y;
    assign w_rom[2] = rom_data_z;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_axis
            axis_slew #(
                .DATA_WIDTH (DATA_WIDTH),
                .STEP       (STEP),
                .CENTER     (CENTER)
            ) u_axis (
                .clk       (clk),
                .rst       (rst),
                .tick      (w_axis_tick),
                .load      (w_axis_load),
                .target    (w_rom[gi]),
                .pos       (w_pos[gi]),
                .at_target (w_at_target[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_pre   <= '0;
            r_dwell <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (stop) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_pre   <= '0;
            r_dwell <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_SLEW;
                    r_pre   <= '0;
                    r_dwell <= '0;
                end
                ST_SLEW: begin
                    r_pre <= w_pre_next;
                    if (&w_at_target) begin
                        r_state <= ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    r_pre <= w_pre_next;
                    if (w_tick) begin
                        if (r_dwell == c_DWELL_LAST) begin
                            r_dwell <= '0;
                            if (r_idx != c_IDX_LAST) begin
                                r_idx   <= r_idx + 1'b1;
                                r_state <= ST_LOAD;
                            end else if (loop) begin
                                r_idx   <= '0;
                                r_state <= ST_LOAD;
                            end else begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_dwell <= r_dwell + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr = r_idx;
    assign pos_x    = w_pos[0];
    assign pos_y    = w_pos[1];
    assign pos_z    = w_pos[2];
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_servo_sequencer.sv
// ============================================================================
// Module      : tb_servo_sequencer
// Description : Directed testbench for servo_sequencer with cycle-exact
//               expected values for a 3-waypoint trajectory.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_servo_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       loop;
    logic [2:0] rom_addr;
    logic [7:0] rom_x, rom_y, rom_z;
    logic [7:0] pos_x, pos_y, pos_z;
    logic       busy, done;

    logic [2:0] rom_addr5;
    logic [7:0] rom_x5, rom_y5, rom_z5;
    logic [7:0] pos_x5, pos_y5, pos_z5;
    logic       busy5, done5;

    int checks;
    int failures;
    int edge_no;

    function automatic logic [7:0] rom_xf(input logic [2:0] a);
        case (a)
            3'd0:    return 8'd130;
            3'd1:    return 8'd126;
            default: return 8'd128;
        endcase
    endfunction

    function automatic logic [7:0] rom_yf(input logic [2:0] a);
        return (a == 3'd1) ? 8'd140 : 8'd128;
    endfunction

    function automatic logic [7:0] rom_zf(input logic [2:0] a);
        return (a == 3'd2) ? 8'd0 : 8'd128;
    endfunction

    always_comb begin
        rom_x  = rom_xf(rom_addr);
        rom_y  = rom_yf(rom_addr);
        rom_z  = rom_zf(rom_addr);
        rom_x5 = rom_xf(rom_addr5);
        rom_y5 = rom_yf(rom_addr5);
        rom_z5 = rom_zf(rom_addr5);
    end

    servo_sequencer #(
        .DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_STEPS(3), .TICK_DIV(4),
        .DWELL_TICKS(2), .STEP(1), .CENTER(128)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
        .rom_addr(rom_addr), .rom_data_x(rom_x), .rom_data_y(rom_y),
        .rom_data_z(rom_z), .pos_x(pos_x), .pos_y(pos_y), .pos_z(pos_z),
        .busy(busy), .done(done)
    );

    servo_sequencer #(
        .DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_STEPS(3), .TICK_DIV(4),
        .DWELL_TICKS(2), .STEP(5), .CENTER(128)
    ) dut5 (
        .clk(clk), .rst(rst), .start(start), .stop(1'b0), .loop(1'b0),
        .rom_addr(rom_addr5), .rom_data_x(rom_x5), .rom_data_y(rom_y5),
        .rom_data_z(rom_z5), .pos_x(pos_x5), .pos_y(pos_y5), .pos_z(pos_z5),
        .busy(busy5), .done(done5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after edge number e (counted from reset release).
    task automatic step_to(input int e);
        while (edge_no < e) begin
            @(posedge clk);
            edge_no++;
        end
        #1;
    endtask

    task automatic check_pos(input string tag, input int x, input int y, input int z);
        check_eq({tag, "_x"}, 32'(pos_x), 32'(x));
        check_eq({tag, "_y"}, 32'(pos_y), 32'(y));
        check_eq({tag, "_z"}, 32'(pos_z), 32'(z));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        edge_no  = 0;
        rst      = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        loop     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_pos("reset", 128, 128, 128);
        check_eq("reset_busy", 32'(busy), 0);
        check_eq("reset_done", 32'(done), 0);
        check_eq("reset_addr", 32'(rom_addr), 0);

        // Run 1: loop=0, full trajectory to DONE
        rst   = 1'b1;
        start = 1'b1;
        step_to(1);
        start = 1'b0;
        check_eq("load_busy", 32'(busy), 1);
        check_eq("load_done", 32'(done), 0);
        check_eq("load_addr", 32'(rom_addr), 0);
        step_to(5);
        check_eq("pre_tick_x", 32'(pos_x), 128);
        check_eq("s5_pre_tick_x", 32'(pos_x5), 128);
        step_to(6);
        check_eq("tick1_x", 32'(pos_x), 129);
        check_eq("s5_tick1_x", 32'(pos_x5), 130);
        step_to(7);
        check_eq("s5_hold_x", 32'(pos_x5), 130);
        step_to(9);
        check_eq("pre_tick2_x", 32'(pos_x), 129);
        step_to(10);
        check_eq("tick2_x", 32'(pos_x), 130);
        check_eq("dwell_busy", 32'(busy), 1);
        step_to(17);
        check_eq("dwell0_addr", 32'(rom_addr), 0);
        step_to(18);
        check_eq("wp1_addr", 32'(rom_addr), 1);
        step_to(67);
        check_pos("wp1_reached", 126, 140, 128);
        step_to(74);
        check_eq("dwell1_addr", 32'(rom_addr), 1);
        step_to(75);
        check_eq("wp2_addr", 32'(rom_addr), 2);
        step_to(587);
        check_eq("z_near_zero", 32'(pos_z), 1);
        check_eq("z_near_busy", 32'(busy), 1);
        step_to(588);
        check_eq("z_zero", 32'(pos_z), 0);
        step_to(595);
        check_eq("pre_done_done", 32'(done), 0);
        check_eq("pre_done_busy", 32'(busy), 1);
        step_to(596);
        check_eq("done_done", 32'(done), 1);
        check_eq("done_busy", 32'(busy), 0);
        check_pos("done_pos", 128, 128, 0);
        step_to(600);
        check_eq("done_hold_z", 32'(pos_z), 0);
        check_eq("done_hold", 32'(done), 1);

        // Run 2: loop=1 restarts at waypoint 0
        start = 1'b1;
        loop  = 1'b1;
        step_to(601);
        start = 1'b0;
        check_eq("run2_busy", 32'(busy), 1);
        step_to(1699);
        check_eq("loop_pre_addr", 32'(rom_addr), 2);
        step_to(1700);
        check_eq("loop_addr", 32'(rom_addr), 0);
        check_eq("loop_busy", 32'(busy), 1);
        check_eq("loop_done", 32'(done), 0);
        step_to(1701);
        check_eq("loop_slew_busy", 32'(busy), 1);

        // stop lands on a slew tick edge during waypoint 1
        step_to(2233);
        check_pos("pre_stop", 128, 130, 128);
        check_eq("pre_stop_addr", 32'(rom_addr), 1);
        stop = 1'b1;
        step_to(2234);
        check_pos("stop", 128, 130, 128);
        check_eq("stop_busy", 32'(busy), 0);
        check_eq("stop_addr", 32'(rom_addr), 0);
        step_to(2240);
        start = 1'b1;
        step_to(2250);
        check_eq("start_stop_busy", 32'(busy), 0);
        check_pos("start_stop", 128, 130, 128);
        start = 1'b0;
        stop  = 1'b0;
        loop  = 1'b0;

        // Run 3: async reset while dwelling at waypoint 0
        step_to(2260);
        start = 1'b1;
        step_to(2261);
        start = 1'b0;
        check_eq("run3_busy", 32'(busy), 1);
        step_to(2271);
        check_pos("run3_dwell", 130, 128, 128);
        check_eq("run3_dwell_busy", 32'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        check_pos("async_rst", 128, 128, 128);
        check_eq("async_rst_busy", 32'(busy), 0);
        check_eq("async_rst_done", 32'(done), 0);
        check_eq("async_rst_addr", 32'(rom_addr), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/servo_sequencer.md
# servo_sequencer

Plays back a stored arm trajectory: steps through ROM waypoints (one 8-bit target per servo axis), slews each servo position toward its target at a fixed rate, holds each waypoint for a dwell time, then advances. Sits between the three waypoint ROMs and the FSM/PWM datapath. Its pos_x/y/z outputs feed the PWM data inputs in playback mode.

## Interface
Parameters:
- DATA_WIDTH, 8: servo position width; ROM data width.
- ADDR_WIDTH, 3: ROM address width.
- NUM_STEPS, 8: waypoints per trajectory, 1..2^ADDR_WIDTH.
- TICK_DIV, 500000: clk cycles per slew tick (10 ms at 50 MHz), ≥2.
- DWELL_TICKS, 50: slew ticks held at each waypoint, ≥1.
- STEP, 1: max position change per axis per tick, ≥1.
- CENTER, 128: reset/idle position of every axis.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level; begin playback from waypoint 0.
- stop  in  1  level; abort playback, hold positions.
- loop  in  1  at end of last dwell: 1 = restart at waypoint 0, 0 = finish.
- rom_addr  out  ADDR_WIDTH  waypoint index to all three ROMs.
- rom_data_x/y/z  in  DATA_WIDTH each  combinational ROM outputs for rom_addr.
- pos_x/y/z  out  DATA_WIDTH each  current servo positions, registered.
- busy  out  1  high in LOAD, SLEW, DWELL.
- done  out  1  high in DONE.

## Operation
- States: IDLE, LOAD, SLEW, DWELL, DONE.
- Reset: state IDLE, idx=0, rom_addr=0, pos_*=CENTER, targets=CENTER, prescaler=0, dwell count=0, busy=0, done=0.
- IDLE/DONE: start=1 and stop=0 → LOAD, idx=0.
- LOAD (1 cycle): rom_addr=idx. Latch rom_data_* into targets → SLEW. Clear prescaler and dwell count.
- SLEW: prescaler counts 0..TICK_DIV-1 and wraps; tick = prescaler==TICK_DIV-1. On a tick, each axis independently:
  - |target-pos| ≤ STEP → pos=target.
  - otherwise → pos moves STEP toward target.
  - Use unsigned compare; no overshoot or wrap.
- Exit from SLEW: at the edge where all three pos equal their targets, go to DWELL. This is checked after the update, so the last slew tick's edge enters DWELL. Targets equal to pos on entry → DWELL one cycle after LOAD, no tick needed.
- DWELL: prescaler keeps running. Dwell count increments per tick. At the tick where count reaches DWELL_TICKS:
  - idx<NUM_STEPS-1 → idx+1, LOAD.
  - idx=NUM_STEPS-1, loop=1 → idx=0, LOAD.
  - idx=NUM_STEPS-1, loop=0 → DONE.
- stop=1 in any state → IDLE at the next edge. pos_* held; idx cleared. stop has priority over start and over every transition in the same cycle.
- DONE holds pos_* at the final waypoint.
- rom_addr always equals idx.

## Timing
- start sampled at edge k → LOAD after k, SLEW (or DWELL) after k+1.
- Targets latched at the LOAD edge from rom_data_* at rom_addr=idx. The ROM must be combinational, valid within the cycle.
- The first slew tick occurs TICK_DIV cycles after entering SLEW.
- Slew duration per axis is ceil(|Δ|/STEP) ticks; the waypoint slew takes the maximum over the three axes.
- All outputs registered; busy/done change on the same edge as the state.
- Asynchronous reset mid-playback returns all outputs to reset values immediately.

## Structure
- Shared package: state enum (IDLE, LOAD, SLEW, DWELL, DONE) and CENTER default, reused by the top-level mode FSM.
- Sub-module axis_slew (instantiated ×3): inputs tick, load, target; output pos. Implements the step/clamp rule and an at_target flag.
- Prescaler and dwell counter live in the sequencer.

## Test plan
Parameters for all scenarios: TICK_DIV=4, DWELL_TICKS=2, STEP=1, NUM_STEPS=3. ROM: x={130,126,128}, y={128,140,128}, z={128,128,0}.
- Reset → pos_*=128, busy=0, done=0, rom_addr=0. start pulse → LOAD, then SLEW. x reaches 130 after 2 ticks (8+ cycles). Then DWELL of 2 ticks.
- Full run, loop=0 → waypoints 0,1,2 visited in order; rom_addr 0→1→2. Final pos=(128,128,0). Then DONE, done=1, busy=0. No underflow on z reaching 0.
- loop=1 → after waypoint 2 dwell, rom_addr=0 and LOAD again. busy stays 1.
- STEP=5, target 130 from 128 → pos jumps to 130 in one tick; no overshoot.
- stop asserted mid-SLEW on waypoint 1 → IDLE next edge, pos held. start and stop together → stays IDLE.
- Async rst low mid-DWELL → pos_*=128, state IDLE immediately, independent of clk.
